// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its busy-bit scoreboard.
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH     = 32;
   localparam int DEFAULT_ADDR_WIDTH     = 5;
   localparam int DEFAULT_NUM_READ_PORTS = 2;

   // Index of the register that can be hardwired to zero
   localparam int ZERO_IDX = 0;

   // Busy_Count must hold 0..NUM_REGS, so it needs one bit more than an index
   function automatic int popcount_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers waiting for a writeback so decode can
// stall on RAW/WAW hazards. Flush beats issue, and issue beats writeback clear.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int ZERO_REG   = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [ADDR_WIDTH-1:0]               issue_reg,
   input  logic                                sig_issue,
   input  logic                                flush,
   input  logic [ADDR_WIDTH-1:0]               write_reg,
   input  logic                                sig_reg_write,
   output logic [(2**ADDR_WIDTH)-1:0]          busy,
   output logic                                issue_ready,
   output logic [popcount_width(ADDR_WIDTH)-1:0] busy_count
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam int CW       = popcount_width(ADDR_WIDTH);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [CW-1:0]       count_q, count_d;
   logic                issue_is_zero;
   logic                accept;

   assign issue_is_zero = (ZERO_REG != 0) && (issue_reg == ADDR_WIDTH'(ZERO_IDX));
   assign issue_ready   = !busy_q[issue_reg] || issue_is_zero;
   assign accept        = sig_issue && issue_ready && !flush;

   // Next busy vector: writeback clear, then issue set, then flush wipes all
   always_comb begin
      busy_d = busy_q;
      if (sig_reg_write) begin
         busy_d[write_reg] = 1'b0;
      end
      if (accept && !issue_is_zero) begin
         busy_d[issue_reg] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end
   end

   // Population count of the next busy vector, so the count tracks the bits exactly
   always_comb begin
      count_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         count_d = count_d + CW'(busy_d[i]);
      end
   end

   // Busy bits and their count update together on the edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy       = busy_q;
   assign busy_count = count_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// Register file with combinational read ports, write-to-read forwarding,
// optional hardwired zero register and an attached busy-bit scoreboard.
module register_file_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int NUM_READ_PORTS = DEFAULT_NUM_READ_PORTS,
   parameter int ZERO_REG       = 1
) (
   input  logic                                   Clk,
   input  logic                                   Reset,
   input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]   Read_Register,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   Read_Data,
   output logic [NUM_READ_PORTS-1:0]              Read_Busy,
   input  logic [ADDR_WIDTH-1:0]                  Write_Register,
   input  logic [DATA_WIDTH-1:0]                  Write_Data,
   input  logic                                   Sig_Reg_Write,
   input  logic [ADDR_WIDTH-1:0]                  Issue_Register,
   input  logic                                   Sig_Issue,
   output logic                                   Issue_Ready,
   input  logic                                   Flush,
   output logic [popcount_width(ADDR_WIDTH)-1:0]  Busy_Count
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic                  writable;

   // Writes to the hardwired zero register are dropped everywhere, including forwarding
   assign writable = Sig_Reg_Write &&
                     !((ZERO_REG != 0) && (Write_Register == ADDR_WIDTH'(ZERO_IDX)));

   // Next storage contents: only the addressed register changes
   always_comb begin
      regs_d = regs_q;
      if (writable) begin
         regs_d[Write_Register] = Write_Data;
      end
   end

   // Storage array, cleared asynchronously
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Each read port: zero register, then forwarded write data, then storage
   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
      logic [ADDR_WIDTH-1:0] idx;
      logic                  idx_zero;
      logic                  fwd_hit;

      assign idx      = Read_Register[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign idx_zero = (ZERO_REG != 0) && (idx == ADDR_WIDTH'(ZERO_IDX));
      assign fwd_hit  = writable && (Write_Register == idx);

      assign Read_Data[p*DATA_WIDTH +: DATA_WIDTH] =
         idx_zero ? '0 : (fwd_hit ? Write_Data : regs_q[idx]);
      assign Read_Busy[p] = busy[idx] && !fwd_hit && !idx_zero;
   end

   reg_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .clk           (Clk),
      .rst           (Reset),
      .issue_reg     (Issue_Register),
      .sig_issue     (Sig_Issue),
      .flush         (Flush),
      .write_reg     (Write_Register),
      .sig_reg_write (Sig_Reg_Write),
      .busy          (busy),
      .issue_ready   (Issue_Ready),
      .busy_count    (Busy_Count)
   );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed testbench for register_file_scoreboard with hand-computed expectations.
module tb_register_file_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NP = 2;

   logic              Clk;
   logic              Reset;
   logic [NP*AW-1:0]  Read_Register;
   logic [NP*DW-1:0]  Read_Data;
   logic [NP-1:0]     Read_Busy;
   logic [AW-1:0]     Write_Register;
   logic [DW-1:0]     Write_Data;
   logic              Sig_Reg_Write;
   logic [AW-1:0]     Issue_Register;
   logic              Sig_Issue;
   logic              Issue_Ready;
   logic              Flush;
   logic [AW:0]       Busy_Count;

   int numChecks = 0;
   int numFails  = 0;

   register_file_scoreboard #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .NUM_READ_PORTS (NP),
      .ZERO_REG       (1)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Read_Register  (Read_Register),
      .Read_Data      (Read_Data),
      .Read_Busy      (Read_Busy),
      .Write_Register (Write_Register),
      .Write_Data     (Write_Data),
      .Sig_Reg_Write  (Sig_Reg_Write),
      .Issue_Register (Issue_Register),
      .Sig_Issue      (Sig_Issue),
      .Issue_Ready    (Issue_Ready),
      .Flush          (Flush),
      .Busy_Count     (Busy_Count)
   );

   // Free-running 10-unit clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Sig_Reg_Write  = 1'b0;
      Sig_Issue      = 1'b0;
      Flush          = 1'b0;
      Write_Register = '0;
      Write_Data     = '0;
      Issue_Register = '0;
   endtask

   task automatic setRead(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      Read_Register = {r1, r0};
   endtask

   task automatic test_reset();
      idle();
      setRead(5'd6, 5'd8);
      Reset = 1'b1;
      #3;
      if (Busy_Count !== 6'd0) begin $display("[TB] FAIL reset_count: got %0d want 0", Busy_Count); numFails++; end
      numChecks++;
      Issue_Register = 5'd5;
      #1;
      if (Issue_Ready !== 1'b1) begin $display("[TB] FAIL reset_ready: got %b want 1", Issue_Ready); numFails++; end
      numChecks++;
      Reset = 1'b0;
      // Populate some state before a mid-run reset
      tick();
      Sig_Reg_Write = 1'b1; Write_Register = 5'd8; Write_Data = 32'd77;
      Sig_Issue = 1'b1; Issue_Register = 5'd6;
      tick();
      idle();
      #1;
      if (Read_Data[63:32] !== 32'd77) begin $display("[TB] FAIL prereset_r8: got %0d want 77", Read_Data[63:32]); numFails++; end
      numChecks++;
      if (Busy_Count !== 6'd1 || Read_Busy[0] !== 1'b1) begin
         $display("[TB] FAIL prereset_busy: got count %0d busy %b want 1 1", Busy_Count, Read_Busy[0]); numFails++;
      end
      numChecks++;
      // Reset lands between edges with a write and an issue in flight
      Sig_Reg_Write = 1'b1; Write_Register = 5'd9; Write_Data = 32'd55;
      Sig_Issue = 1'b1; Issue_Register = 5'd10;
      Reset = 1'b1;
      #1;
      if (Busy_Count !== 6'd0 || Read_Busy !== 2'b00) begin
         $display("[TB] FAIL midreset_busy: got count %0d busy %b want 0 00", Busy_Count, Read_Busy); numFails++;
      end
      numChecks++;
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         setRead(AW'(i), AW'(31 - i));
         #1;
         if (Read_Data !== 64'd0) begin $display("[TB] FAIL reset_read r%0d: got %h want 0", i, Read_Data); numFails++; end
         numChecks++;
      end
      Reset = 1'b0;
      tick();
      setRead(5'd10, 5'd9);
      Issue_Register = 5'd10;
      #1;
      if (Busy_Count !== 6'd0 || Issue_Ready !== 1'b1 || Read_Busy[0] !== 1'b0) begin
         $display("[TB] FAIL lost_issue: got count %0d ready %b busy %b want 0 1 0", Busy_Count, Issue_Ready, Read_Busy[0]); numFails++;
      end
      numChecks++;
      if (Read_Data[63:32] !== 32'd0) begin $display("[TB] FAIL lost_write: got %0d want 0", Read_Data[63:32]); numFails++; end
      numChecks++;
   endtask

   task automatic test_zero_reg();
      idle();
      Sig_Reg_Write = 1'b1; Write_Register = 5'd0; Write_Data = 32'd10;
      Sig_Issue = 1'b1; Issue_Register = 5'd0;
      setRead(5'd0, 5'd0);
      #1;
      if (Read_Data[31:0] !== 32'd0) begin $display("[TB] FAIL zero_fwd: got %0d want 0", Read_Data[31:0]); numFails++; end
      numChecks++;
      tick();
      idle();
      #1;
      if (Read_Data[31:0] !== 32'd0) begin $display("[TB] FAIL zero_store: got %0d want 0", Read_Data[31:0]); numFails++; end
      numChecks++;
      if (Busy_Count !== 6'd0 || Read_Busy[0] !== 1'b0 || Issue_Ready !== 1'b1) begin
         $display("[TB] FAIL zero_busy: got count %0d busy %b ready %b want 0 0 1", Busy_Count, Read_Busy[0], Issue_Ready); numFails++;
      end
      numChecks++;
   endtask

   task automatic test_write_read();
      idle();
      Sig_Reg_Write = 1'b1; Write_Register = 5'd3; Write_Data = 32'd20;
      tick();
      idle();
      setRead(5'd3, 5'd4);
      #1;
      if (Read_Data[31:0] !== 32'd20) begin $display("[TB] FAIL wr_r3: got %0d want 20", Read_Data[31:0]); numFails++; end
      numChecks++;
      if (Read_Data[63:32] !== 32'd0) begin $display("[TB] FAIL wr_r4: got %0d want 0", Read_Data[63:32]); numFails++; end
      numChecks++;
   endtask

   task automatic test_forwarding();
      idle();
      setRead(5'd7, 5'd7);
      Sig_Reg_Write = 1'b1; Write_Register = 5'd7; Write_Data = 32'hDEADBEEF;
      #1;
      if (Read_Data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         $display("[TB] FAIL fwd_both: got %h want deadbeefdeadbeef", Read_Data); numFails++;
      end
      numChecks++;
      tick();
      idle();
      Write_Register = 5'd7; Write_Data = 32'h11111111;
      #1;
      if (Read_Data[31:0] !== 32'hDEADBEEF) begin $display("[TB] FAIL fwd_stored: got %h want deadbeef", Read_Data[31:0]); numFails++; end
      numChecks++;
   endtask

   task automatic test_scoreboard();
      idle();
      setRead(5'd5, 5'd5);
      Sig_Issue = 1'b1; Issue_Register = 5'd5;
      #1;
      if (Issue_Ready !== 1'b1 || Read_Busy[0] !== 1'b0) begin
         $display("[TB] FAIL sb_preissue: got ready %b busy %b want 1 0", Issue_Ready, Read_Busy[0]); numFails++;
      end
      numChecks++;
      tick();
      #1;
      if (Read_Busy !== 2'b11 || Busy_Count !== 6'd1) begin
         $display("[TB] FAIL sb_busy: got busy %b count %0d want 11 1", Read_Busy, Busy_Count); numFails++;
      end
      numChecks++;
      if (Issue_Ready !== 1'b0) begin $display("[TB] FAIL sb_stall: got %b want 0", Issue_Ready); numFails++; end
      numChecks++;
      tick();
      idle();
      Sig_Reg_Write = 1'b1; Write_Register = 5'd5; Write_Data = 32'd42;
      Issue_Register = 5'd5;
      #1;
      if (Read_Busy !== 2'b00 || Read_Data[31:0] !== 32'd42 || Busy_Count !== 6'd1) begin
         $display("[TB] FAIL sb_release: got busy %b data %0d count %0d want 00 42 1", Read_Busy, Read_Data[31:0], Busy_Count); numFails++;
      end
      numChecks++;
      if (Issue_Ready !== 1'b0) begin $display("[TB] FAIL sb_write_no_ready: got %b want 0", Issue_Ready); numFails++; end
      numChecks++;
      tick();
      idle();
      #1;
      if (Busy_Count !== 6'd0 || Read_Busy[0] !== 1'b0) begin
         $display("[TB] FAIL sb_cleared: got count %0d busy %b want 0 0", Busy_Count, Read_Busy[0]); numFails++;
      end
      numChecks++;
   endtask

   task automatic test_issue_and_write();
      idle();
      setRead(5'd9, 5'd9);
      Sig_Issue = 1'b1; Issue_Register = 5'd9;
      Sig_Reg_Write = 1'b1; Write_Register = 5'd9; Write_Data = 32'd5;
      tick();
      idle();
      #1;
      if (Read_Data[31:0] !== 32'd5 || Read_Busy[0] !== 1'b1 || Busy_Count !== 6'd1) begin
         $display("[TB] FAIL iw_r9: got data %0d busy %b count %0d want 5 1 1", Read_Data[31:0], Read_Busy[0], Busy_Count); numFails++;
      end
      numChecks++;
      Sig_Reg_Write = 1'b1; Write_Register = 5'd9; Write_Data = 32'd5;
      tick();
      idle();
      #1;
      if (Busy_Count !== 6'd0) begin $display("[TB] FAIL iw_clear: got %0d want 0", Busy_Count); numFails++; end
      numChecks++;
   endtask

   task automatic test_flush();
      idle();
      for (int i = 1; i <= 3; i++) begin
         Sig_Issue = 1'b1; Issue_Register = AW'(i);
         tick();
      end
      idle();
      #1;
      if (Busy_Count !== 6'd3) begin $display("[TB] FAIL flush_pre: got %0d want 3", Busy_Count); numFails++; end
      numChecks++;
      Flush = 1'b1; Sig_Issue = 1'b1; Issue_Register = 5'd4;
      Sig_Reg_Write = 1'b1; Write_Register = 5'd12; Write_Data = 32'h1234;
      tick();
      idle();
      setRead(5'd4, 5'd12);
      Issue_Register = 5'd4;
      #1;
      if (Busy_Count !== 6'd0 || Read_Busy[0] !== 1'b0 || Issue_Ready !== 1'b1) begin
         $display("[TB] FAIL flush_clear: got count %0d busy %b ready %b want 0 0 1", Busy_Count, Read_Busy[0], Issue_Ready); numFails++;
      end
      numChecks++;
      if (Read_Data[63:32] !== 32'h1234) begin $display("[TB] FAIL flush_data: got %h want 1234", Read_Data[63:32]); numFails++; end
      numChecks++;
   endtask

   task automatic test_fill();
      idle();
      for (int i = 1; i < 32; i++) begin
         Sig_Issue = 1'b1; Issue_Register = AW'(i);
         tick();
      end
      idle();
      Issue_Register = 5'd17;
      #1;
      if (Busy_Count !== 6'd31 || Issue_Ready !== 1'b0) begin
         $display("[TB] FAIL fill_count: got count %0d ready %b want 31 0", Busy_Count, Issue_Ready); numFails++;
      end
      numChecks++;
      Flush = 1'b1;
      tick();
      idle();
      #1;
      if (Busy_Count !== 6'd0) begin $display("[TB] FAIL fill_flush: got %0d want 0", Busy_Count); numFails++; end
      numChecks++;
   endtask

   // Scenario sequence
   initial begin
      Reset = 1'b1;
      idle();
      Read_Register = '0;
      test_reset();
      test_zero_reg();
      test_write_read();
      test_forwarding();
      test_scoreboard();
      test_issue_and_write();
      test_flush();
      test_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Parametrised successor to the processor's register file. It holds NUM_REGS registers of DATA_WIDTH bits, with a clocked write port, a configurable number of combinational read ports, same-cycle write-to-read forwarding, and an optional hardwired-zero register 0. A busy-bit scoreboard tracks registers with a pending writeback, so the decode stage can stall on RAW/WAW hazards. It sits between decode (read and issue) and writeback (write).

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- NUM_READ_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, never goes busy
- Clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-high
- Read_Register  input  NUM_READ_PORTS*ADDR_WIDTH  packed read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- Read_Data  output  NUM_READ_PORTS*DATA_WIDTH  packed read data, combinational
- Read_Busy  output  NUM_READ_PORTS  addressed register has a pending writeback
- Write_Register  input  ADDR_WIDTH  write index
- Write_Data  input  DATA_WIDTH  write data
- Sig_Reg_Write  input  1  write enable; also clears the target's busy bit
- Issue_Register  input  ADDR_WIDTH  destination of the instruction being issued
- Sig_Issue  input  1  issue request
- Issue_Ready  output  1  issue is accepted this cycle when Sig_Issue is high
- Flush  input  1  synchronous clear of all busy bits
- Busy_Count  output  ADDR_WIDTH+1  registered count of busy registers

## Operation
- Define "writable" as Sig_Reg_Write && !(ZERO_REG && Write_Register == 0).
- **Storage.** On the rising edge, if writable, the register at Write_Register takes Write_Data.
- **Reads.** Each read port is independent and combinational.
  - If ZERO_REG and the index is 0, the port returns 0.
  - Otherwise, if writable and Write_Register equals the index, the port returns Write_Data (forwarding).
  - Otherwise the port returns the stored value.
- **Read_Busy[i].** Equals busy[index] && !(writable && Write_Register == index). It is always 0 for register 0 when ZERO_REG.
- **Issue_Ready.** Equals !busy[Issue_Register] || (ZERO_REG && Issue_Register == 0). A same-cycle write does not make a busy register ready.
- **Accept.** An issue is accepted when Sig_Issue && Issue_Ready && !Flush. Acceptance sets busy[Issue_Register] on the edge, except for register 0 when ZERO_REG.
- **Busy-bit update priority, per register, at the edge:**
  - Flush clears all busy bits.
  - Otherwise an accepted issue sets the bit.
  - Otherwise a write (Sig_Reg_Write, index matching) clears it.
  - If issue and write target the same register in the same cycle, the bit ends at 1.
- **Flush and data.** Flush never blocks or alters data writes.
- **Busy_Count.** Updated each edge to the population count of the next busy vector. Its range is 0..NUM_REGS, with no wrap.

## Timing
- **Reset (async).** All registers, all busy bits and Busy_Count go to 0. Issue_Ready reads 1 and Read_Busy reads 0 while Reset is held.
- **Write.** Visible through forwarding in the same cycle. Visible from storage from the cycle after the edge.
- **Issue.** The busy bit, Read_Busy and Busy_Count reflect an accepted issue from the cycle after the edge.
- **Writeback clear.** Read_Busy drops in the same cycle as the write, via the forwarding term. The stored busy bit clears at the edge.
- **Mid-operation reset.** Reset asserted between edges takes effect immediately. A write or issue in that cycle is lost.
- **Read-port conflicts.** Multiple read ports on the same index are always legal and return identical data.

## Structure
- Shared package regfile_pkg holds:
  - the default DATA_WIDTH, ADDR_WIDTH and NUM_READ_PORTS;
  - the zero-index constant;
  - a function returning the popcount width, ADDR_WIDTH+1.
- One sub-module, reg_scoreboard, owns the busy vector, the set/clear/flush priority, Issue_Ready and Busy_Count.
- The top level owns storage, the read multiplexers and forwarding.

## Test plan
- **Reset and zero register.** Assert Reset mid-run, then read r0..r31 → all 0 and Busy_Count=0. Write r0=10 with ZERO_REG=1, then read r0 → 0.
- **Write then read.** Write r3=20, next cycle read r3 and r4 on ports 0/1 → 20 and 0.
- **Forwarding.** In the same cycle, write r7=0xDEADBEEF and read r7 on both ports → both 0xDEADBEEF, before the edge.
- **Scoreboard stall and release.**
  - Issue r5 → next cycle Read_Busy=1 for r5, Busy_Count=1.
  - Sig_Issue to r5 again → Issue_Ready=0 and not accepted.
  - Write r5=42 → same cycle Read_Busy=0; next cycle Busy_Count=0.
- **Simultaneous issue and write.** With r9 not busy, issue r9 and write r9=5 in the same cycle → r9=5 and busy[r9]=1 afterwards.
- **Flush.**
  - Issue r1, r2, r3 on consecutive cycles → Busy_Count=3.
  - Assert Flush together with Sig_Issue on r4 → next cycle Busy_Count=0, r4 not busy.
  - Check that data written during the Flush cycle is stored.
